// File: rtl/gpio_in_cond.sv
// GPIO input conditioning: 2-flop sync, per-pin debounce, edge detect,
// sticky pending flags and a single interrupt line.
module gpio_in_cond #(
  parameter int N    = 16,
  parameter int DB_W = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic [N-1:0]    pins_i,
  input  logic [DB_W-1:0] db_limit_i,
  input  logic [N-1:0]    rise_en_i,
  input  logic [N-1:0]    fall_en_i,
  input  logic [N-1:0]    clr_i,
  output logic [N-1:0]    val_o,
  output logic [N-1:0]    pend_o,
  output logic            irq_o
);

  logic [N-1:0]    s1;
  logic [N-1:0]    s2;
  logic [N-1:0]    upd;
  logic [N-1:0]    rise;
  logic [N-1:0]    fall;
  logic [DB_W-1:0] cnt [N];

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= pins_i;
      s2 <= s1;
    end
  end

  // >= keeps a lowered limit safe mid-count; cnt saturates via update
  always_comb begin
    upd = '0;
    for (int i = 0; i < N; i++) begin
      upd[i] = (s2[i] != val_o[i]) && (cnt[i] >= db_limit_i);
    end
  end

  assign rise = upd &  s2 & rise_en_i;
  assign fall = upd & ~s2 & fall_en_i;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      val_o <= '0;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (s2[i] == val_o[i]) begin
          cnt[i] <= '0;
        end else if (upd[i]) begin
          val_o[i] <= s2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // new events win over a simultaneous clear
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      pend_o <= '0;
    end else begin
      pend_o <= (pend_o & ~clr_i) | rise | fall;
    end
  end

  assign irq_o = |pend_o;

endmodule

// File: tb/tb_gpio_in_cond.sv
// Bench for gpio_in_cond: directed scenarios plus random traffic,
// checked every cycle against a window-based reference model.
module tb_gpio_in_cond;
  localparam int N    = 16;
  localparam int DB_W = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    pins;
  logic [DB_W-1:0] lim;
  logic [N-1:0]    rise_en;
  logic [N-1:0]    fall_en;
  logic [N-1:0]    clr;
  logic [N-1:0]    val;
  logic [N-1:0]    pend;
  logic            irq;

  int n_cmp = 0;
  int n_err = 0;

  logic [N-1:0] mval;
  logic [N-1:0] mpend;
  logic [N-1:0] hq[$];

  gpio_in_cond #(.N(N), .DB_W(DB_W)) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .pins_i     (pins),
    .db_limit_i (lim),
    .rise_en_i  (rise_en),
    .fall_en_i  (fall_en),
    .clr_i      (clr),
    .val_o      (val),
    .pend_o     (pend),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // history holds the pin level sampled at each edge; zeros model reset
  function automatic void model_reset();
    mval  = '0;
    mpend = '0;
    hq.delete();
    for (int i = 0; i < 40; i++) hq.push_back('0);
  endfunction

  // a pin's value flips once the last L+1 synchronised samples all differ
  function automatic void model_edge();
    logic [N-1:0] nv;
    logic [N-1:0] r;
    logic [N-1:0] f;
    int L;
    int sz;
    nv = mval;
    r  = '0;
    f  = '0;
    L  = int'(lim);
    sz = hq.size();
    for (int i = 0; i < N; i++) begin
      bit diff;
      diff = 1'b1;
      for (int j = 0; j <= L; j++) begin
        if (hq[sz-2-j][i] == mval[i]) diff = 1'b0;
      end
      if (diff) begin
        nv[i] = ~mval[i];
        if (nv[i]) r[i] = rise_en[i];
        else       f[i] = fall_en[i];
      end
    end
    mpend = (mpend & ~clr) | r | f;
    mval  = nv;
    hq.push_back(pins);
    if (hq.size() > 64) void'(hq.pop_front());
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("val",  32'(val),  32'(mval));
    chk("pend", 32'(pend), 32'(mpend));
    chk("irq",  32'(irq),  32'(|mpend));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulse_clr(input logic [N-1:0] m);
    clr = m;
    tick();
    clr = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_val",  32'(val),  0);
    chk("rst_pend", 32'(pend), 0);
    chk("rst_irq",  32'(irq),  0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit saw_hi;
    rst_n   = 1'b1;
    pins    = '1;
    lim     = '0;
    rise_en = '1;
    fall_en = '1;
    clr     = '0;
    model_reset();
    #2;

    // pins high through reset
    do_reset();
    ticks(2);
    chk("rel_val2", 32'(val), 0);
    tick();
    chk("rel_val3",  32'(val),  32'h0000FFFF);
    chk("rel_pend3", 32'(pend), 32'h0000FFFF);
    chk("rel_irq3",  32'(irq),  1);

    // latency with L=4
    pins    = '0;
    rise_en = 16'h0001;
    do_reset();
    lim = 16'd4;
    ticks(3);
    pins[0] = 1'b1;
    ticks(5);
    tick();
    chk("lat6", 32'(val[0]), 0);
    tick();
    chk("lat7",      32'(val[0]),  1);
    chk("lat7_pend", 32'(pend[0]), 1);

    // glitch rejection on pin 3
    rise_en = '1;
    pulse_clr('1);
    pins[3] = 1'b1;
    ticks(4);
    pins[3] = 1'b0;
    ticks(12);
    chk("glitch_val",  32'(val[3]),  0);
    chk("glitch_pend", 32'(pend[3]), 0);
    pins[3] = 1'b1;
    ticks(5);
    pins[3] = 1'b0;
    saw_hi = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (val[3]) saw_hi = 1'b1;
    end
    chk("pulse5_hi",  32'(saw_hi), 1);
    chk("pulse5_end", 32'(val[3]), 0);

    // enables: only the fall of pin 5 is recorded
    pulse_clr('1);
    rise_en = '0;
    fall_en = '1;
    pins[5] = 1'b1;
    ticks(8);
    chk("en_rise_drop", 32'(pend[5]), 0);
    rise_en = '1;
    ticks(3);
    chk("en_no_retro", 32'(pend[5]), 0);
    pins[5] = 1'b0;
    ticks(8);
    chk("en_fall", 32'(pend[5]), 1);

    // clear colliding with a new event on pin 2
    pulse_clr('1);
    pins[2] = 1'b1;
    ticks(7);
    chk("col_set", 32'(pend[2]), 1);
    pins[2] = 1'b0;
    ticks(6);
    pulse_clr(16'h0004);
    chk("col_pend", 32'(pend[2]), 1);
    chk("col_irq",  32'(irq),     1);
    pulse_clr(16'h0004);
    chk("clr_pend", 32'(pend[2]), 0);
    chk("clr_irq",  32'(irq),     0);

    // reset in the middle of a count
    lim     = 16'd8;
    pins[0] = 1'b0;
    pins[4] = 1'b1;
    ticks(11);
    chk("mid_pre_pend", 32'(pend), 32'h00000011);
    pins[1] = 1'b1;
    ticks(5);
    do_reset();
    ticks(10);
    chk("mid_val10", 32'(val[1]), 0);
    tick();
    chk("mid_val11", 32'(val[1]), 1);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) lim = DB_W'($urandom_range(0, 6));
      if (c % 97 == 0) begin
        rise_en = N'($urandom);
        fall_en = N'($urandom);
      end
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) pins[i] = ~pins[i];
      end
      clr = N'($urandom & $urandom & $urandom);
      tick();
    end
    clr = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gpio_in_cond.md
Name: gpio_in_cond

Overview:
- Input-conditioning stage directly downstream of the GPIO pin buffers.
- Takes raw, asynchronous pin levels and synchronises them into the wb_clk_i domain.
- Debounces each pin with a programmable stability window, then detects rising and falling edges on the debounced value.
- Holds sticky per-pin pending flags and a single interrupt line, which the GPIO register block exposes to software.

Parameters:
- N, 16: number of pins conditioned (1..32).
- DB_W, 16: width of each per-pin debounce counter and of db_limit_i.

Ports:
- wb_clk_i  input  1  system clock, shared with the Wishbone fabric.
- wb_rst_ni  input  1  asynchronous active-low reset.
- pins_i  input  N  raw pin levels; asynchronous to wb_clk_i.
- db_limit_i  input  DB_W  stability window L in cycles; quasi-static.
- rise_en_i  input  N  per-pin rising-edge event enable.
- fall_en_i  input  N  per-pin falling-edge event enable.
- clr_i  input  N  per-pin pending clear; one-cycle pulse (W1C strobe from the register block).
- val_o  output  N  synchronised, debounced pin value (registered).
- pend_o  output  N  sticky edge-event pending flags (registered).
- irq_o  output  1  interrupt request, equal to the OR of pend_o.

Behaviour:
- Reset:
  - wb_rst_ni low asynchronously clears sync stages s1/s2, all counters, val_o, pend_o and irq_o to 0.
  - Reset is honoured at any point, including mid-count; no partial state survives.
  - After release, the first clock edge resumes normal operation.
- Synchroniser:
  - Per pin, a two-flop chain: s1 <= pins_i, s2 <= s1.
  - No logic between s1 and s2.
- Debounce, per pin i, at each clock edge:
  - If s2[i] == val_o[i]: cnt[i] <= 0.
  - Else if cnt[i] >= db_limit_i: val_o[i] <= s2[i], cnt[i] <= 0. An update event is generated.
  - Else: cnt[i] <= cnt[i] + 1.
  - The >= compare keeps the logic safe if db_limit_i is lowered mid-count; cnt never wraps.
- Latency:
  - A clean step on pins_i, stable before edge 1, appears on val_o at edge L+3.
  - With L = 0, that is 3 cycles (two sync cycles plus one update cycle).
- Glitch rejection:
  - Any excursion of s2 lasting L cycles or fewer returns cnt to 0 and leaves val_o unchanged.
  - It generates no event.
- Edge events, on the same edge as the val_o update:
  - rise[i] = update & new value 1 & rise_en_i[i].
  - fall[i] = update & new value 0 & fall_en_i[i].
- Pending:
  - pend_o[i] <= (pend_o[i] & ~clr_i[i]) | rise[i] | fall[i].
  - Set wins over a simultaneous clear.
  - clr_i on a bit that is not pending has no effect.
  - Toggling the enables never creates or removes pending bits retroactively.
  - Disabled events are dropped, not queued.
- irq_o:
  - Combinational OR of the registered pend_o, so it is glitch-free.
  - Asserts in the same cycle the first pend bit sets.
  - Deasserts in the cycle after the clear of the last pending bit.
- Pins held high through reset:
  - val_o rises L+3 cycles after release.
  - This sets pend if rise_en_i is set; that is intended, and software clears it at init.
- Independence: pins are fully independent; simultaneous events on several pins all set their own bits in the same cycle.
- Widths:
  - cnt is DB_W bits.
  - db_limit_i = all-ones is legal and gives a window of 2^DB_W cycles.

Test Plan:
- Reset/idle: wb_rst_ni=0 with pins_i=16'hFFFF, then release; L=0, rise_en=16'hFFFF -> val_o=0, pend_o=0, irq_o=0 during reset. val_o=16'hFFFF and pend_o=16'hFFFF at edge 3 after release; irq_o=1.
- Latency: L=4, pins_i[0] 0->1 before edge 1 -> val_o[0]=1 at edge 7, not at edge 6. With rise_en_i[0]=1, pend_o[0]=1 on the same edge.
- Glitch: L=4, pins_i[3] high for exactly 4 cycles, then low -> val_o[3] stays 0, pend_o[3] stays 0. A 5-cycle pulse yields val_o[3]=1, then back to 0 (falling edge after a further 5 cycles).
- Enables: rise_en=0, fall_en=1, pin 5 pulse 0->1->0 (each level held >L+1 cycles) -> only the fall sets pend_o[5]. The rise is dropped and no event fires when rise_en is set afterwards.
- Clear collision: pend_o[2]=1, then clr_i[2] pulsed in the same cycle as a new pin-2 event -> pend_o[2] remains 1, irq_o stays 1. A subsequent lone clr_i[2] -> pend_o[2]=0, irq_o=0 next cycle.
- Mid-operation reset: assert wb_rst_ni=0 while cnt[1]=3 with L=8 and pend_o=16'h0011 -> all outputs 0 immediately without a clock edge. After release, pin 1 needs a full L+3 cycles again.
